ext_irq_controller: RTL and testbench

External interrupt controller that drives the processor's `ExtIRQ` input and consumes its `ExtIAck` output. It latches rising edges on up to `NSRC` peripheral interrupt lines, masks them through a register written over the processor's data-memory store bus, selects the lowest-numbered enabled pending source, and holds the request until the core acknowledges it. It sits beside data memory in `processor_arm`'s top level and replaces free-running IRQ stimulus with a protocol-correct requester.

---
 rtl/ext_irq_controller_if.sv | 35 +++
 rtl/ext_irq_controller.sv | 132 +++++++++++++
 tb/tb_ext_irq_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ext_irq_controller_if.sv
// Processor-side bundle for the interrupt controller: data-memory store bus plus
// the ExtIRQ/ExtIAck request handshake.
interface ext_irq_controller_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned NSRC = 8
);
  localparam int unsigned IdW = $clog2(NSRC);

  logic [N-1:0]   DM_addr;
  logic [N-1:0]   DM_writeData;
  logic           DM_writeEnable;
  logic           ExtIAck;
  logic           ExtIRQ;
  logic [IdW-1:0] irq_id;

  // Core side: issues stores and acknowledges requests.
  modport master (
    output DM_addr,
    output DM_writeData,
    output DM_writeEnable,
    output ExtIAck,
    input  ExtIRQ,
    input  irq_id
  );

  // Controller side.
  modport slave (
    input  DM_addr,
    input  DM_writeData,
    input  DM_writeEnable,
    input  ExtIAck,
    output ExtIRQ,
    output irq_id
  );
endinterface

// File: rtl/ext_irq_controller.sv
// External interrupt controller: latches rising edges on peripheral lines, masks them
// via a memory-mapped register, requests the lowest enabled pending source and holds
// ExtIRQ until the core acknowledges, then enforces a low gap before the next request.
module ext_irq_controller #(
  parameter int unsigned    N          = 64,
  parameter int unsigned    NSRC       = 8,
  parameter logic [N-1:0]   MASK_ADDR  = 'h1000,
  parameter int unsigned    GAP_CYCLES = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NSRC-1:0]     irq_src,
  ext_irq_controller_if.slave bus,
  output logic [NSRC-1:0]     irq_pending,
  output logic [NSRC-1:0]     irq_mask,
  output logic [31:0]         irq_count
);

  localparam int unsigned IdW  = $clog2(NSRC);
  // Counter only ever holds GAP_CYCLES-1 down to 0.
  localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES == 0) ? '0 : GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e          stateQ, stateD;
  logic [GapW-1:0] gapCntQ, gapCntD;
  logic [NSRC-1:0] srcQ;
  logic [NSRC-1:0] pendingQ, pendingD;
  logic [NSRC-1:0] maskQ;
  logic [IdW-1:0]  idQ;
  logic [31:0]     countQ;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] reqVec;
  logic [IdW-1:0]  selId;
  logic            anyReq;
  logic            ackTaken;
  logic            loadId;
  logic            maskWrite;
  logic            unusedData;

  assign rise      = irq_src & ~srcQ;
  assign reqVec    = pendingQ & maskQ;
  assign anyReq    = |reqVec;
  assign ackTaken  = (stateQ == StReq) && bus.ExtIAck;
  assign loadId    = (stateQ == StIdle) && anyReq;
  assign maskWrite = bus.DM_writeEnable && (bus.DM_addr == MASK_ADDR);
  assign unusedData = ^bus.DM_writeData[N-1:NSRC];

  // Lowest-numbered enabled pending source; scan downward so the lowest index wins.
  always_comb begin
    selId = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (reqVec[i]) selId = IdW'(i);
    end
  end

  // Pending update: the acknowledged bit clears, but a same-cycle rising edge re-sets it.
  always_comb begin
    clr = '0;
    if (ackTaken) clr[idQ] = 1'b1;
    pendingD = (pendingQ & ~clr) | rise;
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stateQ  <= StIdle;
      gapCntQ <= '0;
    end else begin
      stateQ  <= stateD;
      gapCntQ <= gapCntD;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateD  = stateQ;
    gapCntD = gapCntQ;
    unique case (stateQ)
      StIdle: begin
        if (anyReq) stateD = StReq;
      end
      StReq: begin
        if (bus.ExtIAck) begin
          if (GAP_CYCLES == 0) begin
            stateD = StIdle;
          end else begin
            stateD  = StGap;
            gapCntD = GapLoad;
          end
        end
      end
      StGap: begin
        if (gapCntQ == '0) stateD = StIdle;
        else gapCntD = gapCntQ - 1'b1;
      end
      default: stateD = StIdle;
    endcase
  end

  // FSM outputs: request is a pure function of state, so it is glitch-free.
  always_comb begin
    bus.ExtIRQ = (stateQ == StReq);
    bus.irq_id = idQ;
  end

  // Edge detector, pending latches, mask register, request id and ack counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      srcQ     <= '0;
      pendingQ <= '0;
      maskQ    <= '1;
      idQ      <= '0;
      countQ   <= '0;
    end else begin
      srcQ     <= irq_src;
      pendingQ <= pendingD;
      if (maskWrite) maskQ <= bus.DM_writeData[NSRC-1:0];
      // id is only loaded on the IDLE->REQ transition so it stays stable through REQ.
      if (loadId) idQ <= selId;
      if (ackTaken) countQ <= countQ + 32'd1;
    end
  end

  assign irq_pending = pendingQ;
  assign irq_mask    = maskQ;
  assign irq_count   = countQ;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed bench for ext_irq_controller with hand-computed expectations (GAP_CYCLES = 4).
module tb_ext_irq_controller;

  localparam int unsigned N    = 64;
  localparam int unsigned NSRC = 8;
  localparam logic [N-1:0] MaskAddr = 64'h0000_0000_0000_1000;

  logic        CLOCK_50;
  logic        reset;
  logic [7:0]  irq_src;
  logic [7:0]  irq_pending;
  logic [7:0]  irq_mask;
  logic [31:0] irq_count;

  int nChecks;
  int nPass;
  int lowCnt;

  ext_irq_controller_if #(.N(N), .NSRC(NSRC)) bus ();

  ext_irq_controller #(
    .N(N),
    .NSRC(NSRC),
    .MASK_ADDR(MaskAddr),
    .GAP_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .irq_src(irq_src),
    .bus(bus),
    .irq_pending(irq_pending),
    .irq_mask(irq_mask),
    .irq_count(irq_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    bus.DM_addr        = addr;
    bus.DM_writeData   = data;
    bus.DM_writeEnable = 1'b1;
    tick();
    bus.DM_writeEnable = 1'b0;
  endtask

  task automatic ackOnce();
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
  endtask

  // Current observation is a low cycle; count low cycles until ExtIRQ rises (bounded).
  task automatic waitReq(output int lows);
    int guard;
    lows  = 1;
    guard = 0;
    tick();
    while (!bus.ExtIRQ && guard < 20) begin
      lows++;
      guard++;
      tick();
    end
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    reset   = 1'b1;
    irq_src = '0;
    bus.DM_addr        = '0;
    bus.DM_writeData   = '0;
    bus.DM_writeEnable = 1'b0;
    bus.ExtIAck        = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    checkVal("rst_irq",     64'(bus.ExtIRQ), 64'd0);
    checkVal("rst_id",      64'(bus.irq_id), 64'd0);
    checkVal("rst_pending", 64'(irq_pending), 64'h00);
    checkVal("rst_mask",    64'(irq_mask), 64'hFF);
    checkVal("rst_count",   64'(irq_count), 64'd0);

    // Single event on source 3, acknowledged after three request cycles.
    irq_src = 8'h08;
    tick();
    checkVal("t1_pending_set", 64'(irq_pending), 64'h08);
    checkVal("t1_irq_lat1",    64'(bus.ExtIRQ), 64'd0);
    tick();
    checkVal("t1_irq_on",  64'(bus.ExtIRQ), 64'd1);
    checkVal("t1_id",      64'(bus.irq_id), 64'd3);
    tick();
    tick();
    checkVal("t1_irq_held", 64'(bus.ExtIRQ), 64'd1);
    checkVal("t1_id_held",  64'(bus.irq_id), 64'd3);
    irq_src = 8'h00;
    ackOnce();
    checkVal("t1_irq_off",  64'(bus.ExtIRQ), 64'd0);
    checkVal("t1_pending0", 64'(irq_pending), 64'h00);
    checkVal("t1_count",    64'(irq_count), 64'd1);
    repeat (6) tick();

    // Sources 5 and 2 together: 2 first, then 5 after exactly five low cycles.
    irq_src = 8'h24;
    tick();
    checkVal("t2_pending", 64'(irq_pending), 64'h24);
    tick();
    checkVal("t2_irq_on", 64'(bus.ExtIRQ), 64'd1);
    checkVal("t2_id_lo",  64'(bus.irq_id), 64'd2);
    ackOnce();
    checkVal("t2_irq_off", 64'(bus.ExtIRQ), 64'd0);
    checkVal("t2_pending_after", 64'(irq_pending), 64'h20);
    waitReq(lowCnt);
    checkVal("t2_second_req", 64'(bus.ExtIRQ), 64'd1);
    checkVal("t2_gap_len",    64'(lowCnt), 64'd5);
    checkVal("t2_id_hi",      64'(bus.irq_id), 64'd5);
    irq_src = 8'h00;
    ackOnce();
    checkVal("t2_count", 64'(irq_count), 64'd3);
    repeat (6) tick();

    // Mask: upper data bits are ignored; masked source latches but is not requested.
    store(MaskAddr, 64'hFFFF_FFFF_FFFF_FFF7);
    checkVal("t3_mask_f7", 64'(irq_mask), 64'hF7);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    repeat (3) tick();
    checkVal("t3_masked_irq",     64'(bus.ExtIRQ), 64'd0);
    checkVal("t3_masked_pending", 64'(irq_pending), 64'h08);
    store(MaskAddr + 64'd8, 64'h0);
    checkVal("t3_other_addr", 64'(irq_mask), 64'hF7);
    store(MaskAddr, 64'hFF);
    checkVal("t3_mask_ff",     64'(irq_mask), 64'hFF);
    checkVal("t3_irq_not_yet", 64'(bus.ExtIRQ), 64'd0);
    tick();
    checkVal("t3_unmasked_irq", 64'(bus.ExtIRQ), 64'd1);
    checkVal("t3_unmasked_id",  64'(bus.irq_id), 64'd3);
    ackOnce();
    checkVal("t3_count", 64'(irq_count), 64'd4);
    repeat (6) tick();

    // Set/clear collision: source 1 re-rises on the acknowledge edge.
    irq_src = 8'h02;
    tick();
    tick();
    checkVal("t4_id", 64'(bus.irq_id), 64'd1);
    irq_src = 8'h00;
    tick();
    irq_src     = 8'h02;
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    checkVal("t4_pending_kept", 64'(irq_pending), 64'h02);
    checkVal("t4_count",        64'(irq_count), 64'd5);
    checkVal("t4_irq_off",      64'(bus.ExtIRQ), 64'd0);
    waitReq(lowCnt);
    checkVal("t4_rereq",   64'(bus.ExtIRQ), 64'd1);
    checkVal("t4_gap_len", 64'(lowCnt), 64'd5);
    checkVal("t4_id2",     64'(bus.irq_id), 64'd1);
    irq_src = 8'h00;
    ackOnce();
    checkVal("t4_count2", 64'(irq_count), 64'd6);
    repeat (6) tick();

    // Spurious acknowledge in IDLE is ignored.
    bus.ExtIAck = 1'b1;
    tick();
    tick();
    bus.ExtIAck = 1'b0;
    checkVal("t5_spurious_count", 64'(irq_count), 64'd6);
    checkVal("t5_spurious_irq",   64'(bus.ExtIRQ), 64'd0);

    // Reset during REQ drops the request and restores every output.
    store(MaskAddr, 64'h7F);
    irq_src = 8'h01;
    tick();
    tick();
    checkVal("t5_req_before_rst", 64'(bus.ExtIRQ), 64'd1);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    irq_src = 8'h00;
    checkVal("t5_rst_irq",     64'(bus.ExtIRQ), 64'd0);
    checkVal("t5_rst_pending", 64'(irq_pending), 64'h00);
    checkVal("t5_rst_mask",    64'(irq_mask), 64'hFF);
    checkVal("t5_rst_count",   64'(irq_count), 64'd0);
    checkVal("t5_rst_id",      64'(bus.irq_id), 64'd0);
    repeat (3) tick();
    checkVal("t5_stays_idle", 64'(bus.ExtIRQ), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
